// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART constants: default frame/baud settings and the receiver FSM state codes.
// The TX side is expected to import the same defaults.
package uart_rx_8n1_pkg;

  localparam int unsigned DATA_BIT_DEF   = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned CLK_DIV_DEF    = 27;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_START = 2'd1;
  localparam logic [STATE_W-1:0] S_DATA  = 2'd2;
  localparam logic [STATE_W-1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: o_tick pulses for one clk every CLK_DIV clks.
// The pulse is registered and coincides with the counter sitting at CLK_DIV-1.
module baud_tick_gen
  import uart_rx_8n1_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // Tick is raised one clk early so it is high while cnt == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      cnt    <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      o_tick <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: oversampled mid-bit sampling, one-clk done / frame-error pulses.
// Synchroniser, FSM and shift register live here; the baud tick comes from baud_tick_gen.
module uart_rx_8n1
  import uart_rx_8n1_pkg::*;
#(
  parameter int unsigned DATA_BIT   = DATA_BIT_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_rx_done_tick,
  output logic                o_frame_err,
  output logic                o_busy
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = $clog2(DATA_BIT);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_END  = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BIT - 1);

  logic                rx_meta, rx_s, rx_d;
  logic                s_tick;
  logic [STATE_W-1:0]  state, state_nx;
  logic [S_W-1:0]      s_cnt, s_cnt_nx;
  logic [N_W-1:0]      n_cnt, n_cnt_nx;
  logic [DATA_BIT-1:0] shift_reg, shift_nx, data_nx;
  logic                done_nx, ferr_nx;

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (s_tick)
  );

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      shift_reg      <= '0;
      o_data         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state          <= state_nx;
      s_cnt          <= s_cnt_nx;
      n_cnt          <= n_cnt_nx;
      shift_reg      <= shift_nx;
      o_data         <= data_nx;
      o_rx_done_tick <= done_nx;
      o_frame_err    <= ferr_nx;
      o_busy         <= (state_nx != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    s_cnt_nx = s_cnt;
    n_cnt_nx = n_cnt;
    shift_nx = shift_reg;
    data_nx  = o_data;
    done_nx  = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      // Edge search runs every clk so a start edge is never missed between ticks.
      S_IDLE: begin
        if (rx_d && !rx_s) begin
          state_nx = S_START;
          s_cnt_nx = '0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (s_cnt == S_MID) begin
            if (!rx_s) begin
              state_nx = S_DATA;
              s_cnt_nx = '0;
              n_cnt_nx = '0;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (s_cnt == S_END) begin
            shift_nx = {rx_s, shift_reg[DATA_BIT-1:1]};
            s_cnt_nx = '0;
            if (n_cnt == N_LAST) state_nx = S_STOP;
            else                 n_cnt_nx = n_cnt + 1'b1;
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (s_cnt == S_END) begin
            state_nx = S_IDLE;
            if (rx_s) begin
              data_nx = shift_reg;
              done_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: directed scenarios plus random frames
// compared against a frame-level event model.
module tb_uart_rx_8n1;

  localparam int unsigned CLK_DIV    = 27;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned BIT_CLK    = CLK_DIV * OVERSAMPLE;
  localparam logic [8:0]  FERR_EV    = 9'h100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx = 1'b0;
  logic [7:0] o_data;
  logic       o_rx_done_tick;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  logic [8:0] ev_q[$];

  always #5 clk = ~clk;

  uart_rx_8n1 #(.DATA_BIT(8), .OVERSAMPLE(OVERSAMPLE), .CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx           (i_rx),
    .o_data         (o_data),
    .o_rx_done_tick (o_rx_done_tick),
    .o_frame_err    (o_frame_err),
    .o_busy         (o_busy)
  );

  // Record every output event; good bytes as {0,data}, frame errors as FERR_EV.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_done_tick) ev_q.push_back({1'b0, o_data});
      if (o_frame_err) ev_q.push_back(FERR_EV);
      if (o_rx_done_tick && o_frame_err) both_cnt <= both_cnt + 1;
      if (o_busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 9'h1FF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_clk(BIT_CLK);
    end
    i_rx = stop;
    wait_clk(BIT_CLK);
    i_rx = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         b0;
    logic [8:0] exp_q[$];
    logic [7:0] last_good;

    // 1: reset with line low, released together with the line going idle
    rst  = 1'b1;
    i_rx = 1'b0;
    wait_clk(5);
    rst  = 1'b0;
    i_rx = 1'b1;
    wait_clk(1);
    check_eq("t1_data", 32'(o_data), 32'h00);
    check_eq("t1_busy", 32'(o_busy), 32'd0);
    check_eq("t1_done", 32'(o_rx_done_tick), 32'd0);
    wait_clk(50);
    check_eq("t1_busy_quiet", 32'(busy_cnt), 32'd0);
    check_eq("t1_no_events", 32'(ev_q.size()), 32'd0);

    // 2: single byte
    ev_q.delete();
    send_frame(8'hA5, 1'b1);
    wait_clk(BIT_CLK);
    check_eq("t2_count", 32'(ev_q.size()), 32'd1);
    check_eq("t2_event", 32'(ev_at(0)), 32'h0A5);
    check_eq("t2_data", 32'(o_data), 32'hA5);

    // 3: back-to-back frames
    ev_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(BIT_CLK);
    check_eq("t3_count", 32'(ev_q.size()), 32'd2);
    check_eq("t3_first", 32'(ev_at(0)), 32'h000);
    check_eq("t3_second", 32'(ev_at(1)), 32'h0FF);

    // 4: short low glitch is rejected at the start-bit mid sample
    ev_q.delete();
    b0 = busy_cnt;
    i_rx = 1'b0;
    wait_clk(3 * CLK_DIV);
    i_rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    check_eq("t4_busy_pulsed", 32'(busy_cnt > b0), 32'd1);
    check_eq("t4_busy_idle", 32'(o_busy), 32'd0);
    check_eq("t4_no_events", 32'(ev_q.size()), 32'd0);

    // 5: stop bit low, then line held low (break)
    ev_q.delete();
    send_frame(8'h3C, 1'b0);
    i_rx = 1'b0;
    wait_clk(20 * BIT_CLK);
    i_rx = 1'b1;
    wait_clk(BIT_CLK);
    check_eq("t5_count", 32'(ev_q.size()), 32'd1);
    check_eq("t5_ferr", 32'(ev_at(0)), 32'(FERR_EV));
    check_eq("t5_data_held", 32'(o_data), 32'hFF);
    check_eq("t5_busy_idle", 32'(o_busy), 32'd0);

    // 6: reset in the middle of data bit 4, then a clean frame
    ev_q.delete();
    b = 8'($urandom);
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      i_rx = b[i];
      wait_clk(BIT_CLK);
    end
    i_rx = b[4];
    wait_clk(BIT_CLK / 2);
    rst = 1'b1;
    wait_clk(3);
    rst  = 1'b0;
    i_rx = 1'b1;
    wait_clk(1);
    check_eq("t6_busy_after_rst", 32'(o_busy), 32'd0);
    check_eq("t6_data_after_rst", 32'(o_data), 32'h00);
    wait_clk(BIT_CLK);
    send_frame(8'h81, 1'b1);
    wait_clk(BIT_CLK);
    check_eq("t6_count", 32'(ev_q.size()), 32'd1);
    check_eq("t6_event", 32'(ev_at(0)), 32'h081);
    check_eq("t6_data", 32'(o_data), 32'h81);

    // 7: random frames; a bad stop bit is always followed by idle so the next start edge exists
    ev_q.delete();
    last_good = 8'h81;
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_q.push_back({1'b0, b});
        last_good = b;
        wait_clk(int'($urandom_range(0, 1)) * BIT_CLK + int'($urandom_range(0, 40)));
      end else begin
        exp_q.push_back(FERR_EV);
        wait_clk(BIT_CLK + int'($urandom_range(0, 40)));
      end
    end
    wait_clk(BIT_CLK);
    check_eq("t7_count", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check_eq($sformatf("t7_event%0d", k), 32'(ev_at(k)), 32'(exp_q[k]));
    check_eq("t7_data", 32'(o_data), 32'(last_good));

    check_eq("done_ferr_exclusive", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
